// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer sitting beside the ALU in E.
// Owns the architectural HI/LO registers, models mult/div latency with a
// down-counter, raises the D-stage stall for MDU hazards and flags any
// start that arrives while a mult/div is still in flight.
// Optional feature: define MDU_MADD_EN to accept MADD/MADDU (ops 9/10),
// which add the product into {HI,LO} at completion; when undefined those
// op codes behave exactly like NONE.
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        e_start,
   input  logic [3:0]  e_op,
   input  logic [31:0] e_rs_val,
   input  logic [31:0] e_rt_val,
   input  logic        d_md_use,
   output logic        busy,
   output logic        stall,
   output logic [31:0] mlu_res,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        start_err
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
`endif

   localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       hi_q, lo_q;
   logic [31:0]       phi_q, plo_q;
   logic              acc_q;
   logic              err_q;

   logic              op_mul, op_div, op_acc, op_sgn, op_valid;
   logic [63:0]       prod_d;
   logic [63:0]       quot_d;

   // Full 64-bit product; operands are sign- or zero-extended so that the
   // low 64 bits of the unsigned multiply are the correct result either way.
   function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
      logic [63:0] ea, eb;
      ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
   endfunction

   // Returns {remainder, quotient}. Signed division works on magnitudes:
   // quotient truncates toward zero, remainder follows the dividend sign.
   // 0x8000_0000 / -1 falls out naturally as quotient 0x8000_0000, rem 0.
   // Divide by zero yields quotient all-ones and remainder = dividend.
   function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
      logic        neg_q, neg_r;
      logic [31:0] ua, ub, uq, ur;
      neg_q = sgn & (a[31] ^ b[31]);
      neg_r = sgn & a[31];
      ua    = (sgn & a[31]) ? -a : a;
      ub    = (sgn & b[31]) ? -b : b;
      if (b == 32'd0) begin
         uq = 32'hFFFF_FFFF;
         ur = a;
         neg_q = 1'b0;
         neg_r = 1'b0;
      end else begin
         uq = ua / ub;
         ur = ua % ub;
      end
      return {neg_r ? -ur : ur, neg_q ? -uq : uq};
   endfunction

   // Decode the E-stage op into the classes the sequencer cares about.
   always_comb begin
      op_mul   = (e_op == OP_MULT) | (e_op == OP_MULTU);
      op_div   = (e_op == OP_DIV)  | (e_op == OP_DIVU);
      op_acc   = 1'b0;
      op_sgn   = (e_op == OP_MULT) | (e_op == OP_DIV);
      op_valid = (e_op >= OP_MULT) & (e_op <= OP_MFLO);
`ifdef MDU_MADD_EN
      op_acc   = (e_op == OP_MADD) | (e_op == OP_MADDU);
      op_mul   = op_mul | op_acc;
      op_sgn   = op_sgn | (e_op == OP_MADD);
      op_valid = op_valid | op_acc;
`endif
   end

   assign prod_d    = mul64(e_rs_val, e_rt_val, op_sgn);
   assign quot_d    = div64(e_rs_val, e_rt_val, op_sgn);

   assign busy      = (state_q != S_IDLE);
   assign stall     = d_md_use & (busy | (e_start & (op_mul | op_div)));
   assign mlu_res   = (e_op == OP_MFHI) ? hi_q :
                      (e_op == OP_MFLO) ? lo_q : 32'd0;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign start_err = err_q;

   // Sequencer: latch the pending result at start, count down, commit to HI/LO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         phi_q   <= 32'd0;
         plo_q   <= 32'd0;
         acc_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= busy & e_start & op_valid;
         case (state_q)
            S_IDLE: begin
               if (e_start) begin
                  if (op_mul) begin
                     {phi_q, plo_q} <= prod_d;
                     acc_q          <= op_acc;
                     cnt_q          <= CNT_W'(MULT_CYCLES);
                     state_q        <= S_MUL;
                  end else if (op_div) begin
                     {phi_q, plo_q} <= quot_d;
                     acc_q          <= 1'b0;
                     cnt_q          <= CNT_W'(DIV_CYCLES);
                     state_q        <= S_DIV;
                  end else if (e_op == OP_MTHI) begin
                     hi_q <= e_rs_val;
                  end else if (e_op == OP_MTLO) begin
                     lo_q <= e_rs_val;
                  end
               end
            end
            default: begin
               if (cnt_q == CNT_W'(1)) begin
                  if (acc_q) begin
                     {hi_q, lo_q} <= {hi_q, lo_q} + {phi_q, plo_q};
                  end else begin
                     {hi_q, lo_q} <= {phi_q, plo_q};
                  end
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a transaction-level model (busy cycles
// left, pending 64-bit result computed with plain integer arithmetic) is
// compared against the DUT on every falling edge, and directed scenarios
// pin both the DUT and the model to hand-computed values.
module tb_mdu_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        e_start  = 1'b0;
   logic [3:0]  e_op     = 4'd0;
   logic [31:0] e_rs_val = 32'd0;
   logic [31:0] e_rt_val = 32'd0;
   logic        d_md_use = 1'b0;
   logic        busy, stall, start_err;
   logic [31:0] mlu_res, hi, lo;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   logic [31:0] m_hi   = 32'd0;
   logic [31:0] m_lo   = 32'd0;
   logic [63:0] m_pend = 64'd0;
   logic        m_acc  = 1'b0;
   logic        m_err  = 1'b0;
   int          m_left = 0;

   mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk       (clk),
      .reset     (reset),
      .e_start   (e_start),
      .e_op      (e_op),
      .e_rs_val  (e_rs_val),
      .e_rt_val  (e_rt_val),
      .d_md_use  (d_md_use),
      .busy      (busy),
      .stall     (stall),
      .mlu_res   (mlu_res),
      .hi        (hi),
      .lo        (lo),
      .start_err (start_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic is_valid(input logic [3:0] op);
      if (op >= 4'd1 && op <= 4'd8) return 1'b1;
`ifdef MDU_MADD_EN
      if (op == 4'd9 || op == 4'd10) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic is_long(input logic [3:0] op);
      if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
      if (op == 4'd9 || op == 4'd10) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic exp_stall();
      return d_md_use && ((m_left > 0) || (e_start && is_long(e_op)));
   endfunction

   function automatic logic [31:0] exp_mlu();
      if (e_op == 4'd7) return m_hi;
      if (e_op == 4'd8) return m_lo;
      return 32'd0;
   endfunction

   function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
      int              sa, sb;
      longint unsigned ua, ub;
      sa = a;
      sb = b;
      ua = 64'(a);
      ub = 64'(b);
      if (sgn) return 64'(longint'(sa) * longint'(sb));
      return ua * ub;
   endfunction

   function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
      int          sa, sb, sq, sr;
      int unsigned ua, ub, uq, ur;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = a;
         sb = b;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            sq = sa;
            sr = 0;
         end else begin
            sq = sa / sb;
            sr = sa % sb;
         end
         return {32'(sr), 32'(sq)};
      end
      ua = a;
      ub = b;
      uq = ua / ub;
      ur = ua % ub;
      return {32'(ur), 32'(uq)};
   endfunction

   task automatic model_reset();
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_pend = 64'd0;
      m_acc  = 1'b0;
      m_err  = 1'b0;
      m_left = 0;
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled.
   task automatic model_step();
      logic err;
      if (!reset) begin
         model_reset();
         return;
      end
      err = (m_left > 0) && e_start && is_valid(e_op);
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            if (m_acc) {m_hi, m_lo} = {m_hi, m_lo} + m_pend;
            else       {m_hi, m_lo} = m_pend;
         end
      end else if (e_start) begin
         case (e_op)
            4'd1, 4'd2: begin
               m_pend = model_prod(e_rs_val, e_rt_val, e_op == 4'd1);
               m_acc  = 1'b0;
               m_left = MULT_N;
            end
            4'd3, 4'd4: begin
               m_pend = model_div(e_rs_val, e_rt_val, e_op == 4'd3);
               m_acc  = 1'b0;
               m_left = DIV_N;
            end
            4'd5: m_hi = e_rs_val;
            4'd6: m_lo = e_rs_val;
`ifdef MDU_MADD_EN
            4'd9, 4'd10: begin
               m_pend = model_prod(e_rs_val, e_rt_val, e_op == 4'd9);
               m_acc  = 1'b1;
               m_left = MULT_N;
            end
`endif
            default: ;
         endcase
      end
      m_err = err;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      e_start  = 1'b1;
      e_op     = op;
      e_rs_val = rs;
      e_rt_val = rt;
      tick();
      e_start  = 1'b0;
      e_op     = 4'd0;
      e_rs_val = $urandom;
      e_rt_val = $urandom;
   endtask

   // Count cycles until busy falls; an exhausted budget shows up as a count mismatch.
   task automatic run_until_idle(input string name, input int exp_cycles);
      int n;
      n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      check(name, 32'(n), 32'(exp_cycles));
   endtask

   task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                      input logic [31:0] exp);
      check({name, "_dut"}, dut_v, exp);
      check({name, "_model"}, mdl_v, exp);
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         check("busy", 32'(busy), 32'(m_left > 0));
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
         check("start_err", 32'(start_err), 32'(m_err));
         check("stall", 32'(stall), 32'(exp_stall()));
         check("mlu_res", mlu_res, exp_mlu());
      end
   end

   initial begin
      #2;
      reset = 1'b0;
      model_reset();
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_err", 32'(start_err), 32'd0);
      #3;
      reset = 1'b1;
      tick();

      // MULT -3 * 5
      issue(4'd1, 32'hFFFF_FFFD, 32'd5);
      run_until_idle("mult_lat", MULT_N);
      pin("mult_hi", hi, m_hi, 32'hFFFF_FFFF);
      pin("mult_lo", lo, m_lo, 32'hFFFF_FFF1);

      // DIVU 7 / 2
      issue(4'd4, 32'd7, 32'd2);
      run_until_idle("divu_lat", DIV_N);
      pin("divu_lo", lo, m_lo, 32'd3);
      pin("divu_hi", hi, m_hi, 32'd1);

      // DIV -7 / 2
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      run_until_idle("div_lat", DIV_N);
      pin("div_lo", lo, m_lo, 32'hFFFF_FFFD);
      pin("div_hi", hi, m_hi, 32'hFFFF_FFFF);

      // DIV 9 / 0
      issue(4'd3, 32'd9, 32'd0);
      run_until_idle("div0_lat", DIV_N);
      pin("div0_lo", lo, m_lo, 32'hFFFF_FFFF);
      pin("div0_hi", hi, m_hi, 32'd9);

      // DIVU 5 / 0
      issue(4'd4, 32'd5, 32'd0);
      run_until_idle("divu0_lat", DIV_N);
      pin("divu0_lo", lo, m_lo, 32'hFFFF_FFFF);
      pin("divu0_hi", hi, m_hi, 32'd5);

      // signed overflow
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_until_idle("ovf_lat", DIV_N);
      pin("ovf_lo", lo, m_lo, 32'h8000_0000);
      pin("ovf_hi", hi, m_hi, 32'd0);

      // MULTU large operands
      issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_until_idle("multu_lat", MULT_N);
      pin("multu_hi", hi, m_hi, 32'hFFFF_FFFE);
      pin("multu_lo", lo, m_lo, 32'h0000_0001);

      // MTHI / MTLO then MFHI / MFLO
      issue(4'd5, 32'h0000_1234, 32'd0);
      check("mthi_busy", 32'(busy), 32'd0);
      issue(4'd6, 32'h0000_5678, 32'd0);
      e_op = 4'd7;
      e_start = 1'b1;
      #1;
      check("mfhi_res", mlu_res, 32'h0000_1234);
      e_op = 4'd8;
      #1;
      check("mflo_res", mlu_res, 32'h0000_5678);
      tick();
      e_start = 1'b0;
      e_op = 4'd0;

      // stall while a MULT is in flight
      d_md_use = 1'b1;
      issue(4'd1, 32'd3, 32'd4);
      check("stall_busy", 32'(stall), 32'd1);
      run_until_idle("stall_lat", MULT_N);
      check("stall_idle", 32'(stall), 32'd0);
      d_md_use = 1'b0;
      pin("mul34_lo", lo, m_lo, 32'd12);

      // second start while busy is ignored and flagged
      issue(4'd1, 32'd6, 32'd7);
      e_start  = 1'b1;
      e_op     = 4'd2;
      e_rs_val = 32'hFFFF_FFFF;
      e_rt_val = 32'd2;
      tick();
      e_start  = 1'b0;
      e_op     = 4'd0;
      check("err_pulse", 32'(start_err), 32'd1);
      tick();
      check("err_clear", 32'(start_err), 32'd0);
      run_until_idle("err_lat", MULT_N - 2);
      pin("err_hi", hi, m_hi, 32'd0);
      pin("err_lo", lo, m_lo, 32'd42);

      // MFLO while busy also flags an error
      issue(4'd2, 32'd2, 32'd2);
      e_start = 1'b1;
      e_op    = 4'd8;
      tick();
      e_start = 1'b0;
      e_op    = 4'd0;
      check("mf_busy_err", 32'(start_err), 32'd1);
      run_until_idle("mf_busy_lat", MULT_N - 1);

      // asynchronous reset in the middle of a DIV
      issue(4'd3, 32'd100, 32'd3);
      tick();
      tick();
      reset = 1'b0;
      model_reset();
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_hi", hi, 32'd0);
      check("mid_rst_lo", lo, 32'd0);
      #4;
      reset = 1'b1;
      for (int i = 0; i < DIV_N; i++) tick();
      check("post_rst_lo", lo, 32'd0);

      // reserved and NONE ops are harmless
      issue(4'd5, 32'h0000_A5A5, 32'd0);
      issue(4'd6, 32'h0000_5A5A, 32'd0);
      for (int op = 11; op <= 15; op++) begin
         issue(4'(op), 32'hDEAD_BEEF, 32'd1);
         check("rsv_busy", 32'(busy), 32'd0);
      end
      issue(4'd0, 32'hDEAD_BEEF, 32'd1);
      tick();
      check("rsv_err", 32'(start_err), 32'd0);
      pin("rsv_hi", hi, m_hi, 32'h0000_A5A5);
      pin("rsv_lo", lo, m_lo, 32'h0000_5A5A);

      // MADDU accumulate (or ignore when the feature is absent)
      issue(4'd5, 32'd0, 32'd0);
      issue(4'd6, 32'hFFFF_FFFF, 32'd0);
      issue(4'd10, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      run_until_idle("maddu_lat", MULT_N);
      pin("maddu_hi", hi, m_hi, 32'd1);
      pin("maddu_lo", lo, m_lo, 32'd0);
`else
      check("maddu_busy", 32'(busy), 32'd0);
      tick();
      check("maddu_err", 32'(start_err), 32'd0);
      pin("maddu_hi", hi, m_hi, 32'd0);
      pin("maddu_lo", lo, m_lo, 32'hFFFF_FFFF);
`endif

      // mixed traffic, checked cycle by cycle against the model
      for (int i = 0; i < 60; i++) begin
         e_start  = 1'($urandom_range(0, 1));
         e_op     = 4'($urandom_range(0, 10));
         e_rs_val = $urandom;
         e_rt_val = (i % 7 == 0) ? 32'd0 : $urandom;
         d_md_use = 1'($urandom_range(0, 1));
         tick();
      end
      e_start  = 1'b0;
      e_op     = 4'd0;
      d_md_use = 1'b0;
      for (int i = 0; i < 20 && busy; i++) tick();
      check("final_idle", 32'(busy), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
